// File: rtl/ym_dac_sequencer_if.sv
// Sample handshake between the audio mixer and the DAC sequencer.
interface ym_dac_sequencer_if;
  logic [15:0] SAMPLE_L;
  logic [15:0] SAMPLE_R;
  logic        SAMPLE_VALID;
  logic        SAMPLE_READY;

  modport master (output SAMPLE_L, output SAMPLE_R, output SAMPLE_VALID, input  SAMPLE_READY);
  modport slave  (input  SAMPLE_L, input  SAMPLE_R, input  SAMPLE_VALID, output SAMPLE_READY);
endinterface

// File: rtl/ym_dac_sequencer.sv
// Stereo sample sequencer for a YM3016-style floating-point DAC: double-buffers
// L/R pairs, converts them to mantissa/exponent words and shifts them out with BCLK/SH1/SH2.
module ym_dac_sequencer #(
  parameter int unsigned DIV = 6
) (
  input  logic                CLK,
  input  logic                RESET,
  ym_dac_sequencer_if.slave   s_if,
  output logic                BCLK,
  output logic                OPO,
  output logic                SH1,
  output logic                SH2,
  output logic                RUNNING,
  output logic                UNDERRUN
);

  localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [DW-1:0] r_div;
  logic [4:0]    r_slot;
  logic          r_bclk;
  logic [31:0]   r_frame;
  logic          r_hold_full;
  logic [15:0]   r_hold_l;
  logic [15:0]   r_hold_r;
  logic          r_underrun;

  logic          w_half_end;
  logic          w_wrap;
  logic          w_load;
  logic          w_capture;

  // Channel word: [2:0]=0, [12:3]=mantissa LSB first, [15:13]=exponent LSB first.
  function automatic logic [15:0] conv(input logic [15:0] d);
    logic [5:0] r;
    logic [2:0] sh;
    logic       found;
    logic [3:0] base;
    logic [8:0] mb;
    logic [2:0] e;
    r     = d[15] ? ~d[14:9] : d[14:9];
    sh    = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 6; i++) begin
      if (!found) begin
        if (r[5-i]) found = 1'b1;
        else        sh    = sh + 3'd1;
      end
    end
    base = 4'd14 - {1'b0, sh};
    mb   = d[base -: 9];
    e    = 3'd7 - sh;
    return {e, ~d[15], mb, 3'b000};
  endfunction

  assign w_half_end = (r_div == DW'(DIV - 1));
  assign w_wrap     = (r_state == S_RUN) && w_half_end && r_bclk && (r_slot == 5'd31);
  assign w_capture  = s_if.SAMPLE_VALID && !r_hold_full;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_hold_full) begin
          w_state_nxt = S_RUN;
          w_load      = 1'b1;
        end
      end
      S_RUN:   w_load = w_wrap;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Load and capture both look at the pre-edge hold_full, so a capture in the
  // load cycle survives the clear and an underrun load keeps the old frame.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_div       <= '0;
      r_slot      <= '0;
      r_bclk      <= 1'b0;
      r_frame     <= '0;
      r_hold_full <= 1'b0;
      r_hold_l    <= '0;
      r_hold_r    <= '0;
      r_underrun  <= 1'b0;
    end else begin
      if (w_capture) begin
        r_hold_l <= s_if.SAMPLE_L;
        r_hold_r <= s_if.SAMPLE_R;
      end
      r_hold_full <= w_capture | (r_hold_full & ~w_load);
      r_underrun  <= w_load & ~r_hold_full;
      if (w_load) begin
        if (r_hold_full) r_frame <= {conv(r_hold_r), conv(r_hold_l)};
        r_slot <= '0;
        r_div  <= '0;
        r_bclk <= 1'b0;
      end else if (r_state == S_RUN) begin
        if (w_half_end) begin
          r_div  <= '0;
          r_bclk <= ~r_bclk;
          if (r_bclk) r_slot <= r_slot + 5'd1;
        end else begin
          r_div <= r_div + 1'b1;
        end
      end
    end
  end

  assign RUNNING           = (r_state == S_RUN);
  assign BCLK              = r_bclk;
  assign OPO               = RUNNING & r_frame[r_slot];
  assign SH1               = RUNNING && (r_slot == 5'd15);
  assign SH2               = RUNNING && (r_slot == 5'd31);
  assign UNDERRUN          = r_underrun;
  assign s_if.SAMPLE_READY = ~r_hold_full;

endmodule

// File: tb/tb_ym_dac_sequencer.sv
// Directed bench for ym_dac_sequencer: frame contents, strobes, underrun and handshake timing.
module tb_ym_dac_sequencer;
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic BCLK, OPO, SH1, SH2, RUNNING, UNDERRUN;

  ym_dac_sequencer_if sif ();

  ym_dac_sequencer #(.DIV(6)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .s_if     (sif),
    .BCLK     (BCLK),
    .OPO      (OPO),
    .SH1      (SH1),
    .SH2      (SH2),
    .RUNNING  (RUNNING),
    .UNDERRUN (UNDERRUN)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] g_frame;
  int g_und, g_sh1, g_sh2, g_shbad, g_rise, g_acc, g_rdy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at the falling CLK edge of cycle 0 of a frame; returns at cycle 0 of the next.
  task automatic grab(input int inj, input logic [15:0] l, input logic [15:0] r, input bit keep);
    logic prevb;
    logic cap;
    g_frame = '0;
    g_und = 0; g_sh1 = 0; g_sh2 = 0; g_shbad = 0; g_rise = 0; g_acc = 0; g_rdy = 0;
    prevb = BCLK;
    for (int k = 0; k < 384; k++) begin
      if (k % 12 == 3) g_frame[k/12] = OPO;
      if (SH1) begin g_sh1++; if (k/12 != 15) g_shbad++; end
      if (SH2) begin g_sh2++; if (k/12 != 31) g_shbad++; end
      if (UNDERRUN) g_und++;
      if (sif.SAMPLE_READY) g_rdy++;
      if (BCLK && !prevb) g_rise++;
      prevb = BCLK;
      if (k == inj) begin
        sif.SAMPLE_L = l;
        sif.SAMPLE_R = r;
        sif.SAMPLE_VALID = 1'b1;
      end
      cap = sif.SAMPLE_VALID && sif.SAMPLE_READY;
      @(negedge CLK);
      if (cap) begin
        g_acc++;
        if (!keep) sif.SAMPLE_VALID = 1'b0;
      end
    end
  endtask

  initial begin
    sif.SAMPLE_L = '0;
    sif.SAMPLE_R = '0;
    sif.SAMPLE_VALID = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_running", RUNNING, 0);
    chk("rst_bclk", BCLK, 0);
    chk("rst_ready", sif.SAMPLE_READY, 1);
    RESET = 1'b0;

    // T1: 7FFF / 8000 from IDLE
    @(negedge CLK);
    sif.SAMPLE_L = 16'h7FFF; sif.SAMPLE_R = 16'h8000; sif.SAMPLE_VALID = 1'b1;
    @(negedge CLK);
    chk("t1_ready_low", sif.SAMPLE_READY, 0);
    chk("t1_idle", RUNNING, 0);
    sif.SAMPLE_VALID = 1'b0;
    @(negedge CLK);
    chk("t1_running", RUNNING, 1);

    grab(20, 16'h0000, 16'h0123, 1'b0);
    chk("f1_frame", g_frame, 32'hE000_FFF8);
    chk("f1_und", g_und, 0);
    chk("f1_sh1", g_sh1, 12);
    chk("f1_sh2", g_sh2, 12);
    chk("f1_shbad", g_shbad, 0);
    chk("f1_rise", g_rise, 32);
    chk("f1_acc", g_acc, 1);

    grab(-1, 16'h0, 16'h0, 1'b0);
    chk("f2_frame", g_frame, 32'h3918_3000);
    chk("f2_und", g_und, 0);

    grab(-1, 16'h0, 16'h0, 1'b0);
    chk("f3_frame", g_frame, 32'h3918_3000);
    chk("f3_und", g_und, 1);

    grab(100, 16'h1000, 16'hFFFF, 1'b0);
    chk("f4_frame", g_frame, 32'h3918_3000);
    chk("f4_und", g_und, 1);
    chk("f4_acc", g_acc, 1);

    // T5: VALID held high across frames
    grab(0, 16'h7FFF, 16'h8000, 1'b1);
    chk("f5_frame", g_frame, 32'h2FF8_B800);
    chk("f5_und", g_und, 0);
    chk("f5_acc", g_acc, 1);
    chk("f5_rdy", g_rdy, 1);

    grab(-1, 16'h0, 16'h0, 1'b1);
    chk("f6_frame", g_frame, 32'hE000_FFF8);
    chk("f6_acc", g_acc, 1);
    chk("f6_rdy", g_rdy, 1);
    sif.SAMPLE_VALID = 1'b0;

    grab(-1, 16'h0, 16'h0, 1'b0);
    chk("f7_frame", g_frame, 32'hE000_FFF8);
    chk("f7_und", g_und, 0);
    chk("f7_rdy", g_rdy, 384);

    // Capture lands on the underrun load edge
    grab(383, 16'h1000, 16'hFFFF, 1'b0);
    chk("f8_und", g_und, 1);
    chk("f8_acc", g_acc, 1);

    grab(-1, 16'h0, 16'h0, 1'b0);
    chk("f9_frame", g_frame, 32'hE000_FFF8);
    chk("f9_und", g_und, 1);
    chk("f9_rdy", g_rdy, 0);

    grab(-1, 16'h0, 16'h0, 1'b0);
    chk("f10_frame", g_frame, 32'h2FF8_B800);
    chk("f10_und", g_und, 0);
    chk("f10_rdy", g_rdy, 384);

    // T6: reset in the middle of slot 20
    repeat (20*12 + 5) @(negedge CLK);
    chk("t6_running", RUNNING, 1);
    #2 RESET = 1'b1;
    #1;
    chk("t6_outs", {BCLK, OPO, SH1, SH2, RUNNING, UNDERRUN}, 0);
    chk("t6_ready", sif.SAMPLE_READY, 1);
    @(negedge CLK);
    RESET = 1'b0;
    begin
      int bhi = 0;
      int rhi = 0;
      for (int k = 0; k < 60; k++) begin
        @(negedge CLK);
        if (BCLK) bhi++;
        if (RUNNING) rhi++;
      end
      chk("t6_bclk_idle", bhi, 0);
      chk("t6_stay_idle", rhi, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
